// File: rtl/multi_axis_step_generator.sv
// Coordinated multi-axis step/dir generator: each segment spreads per-axis step counts over a master tick train.
// Latency: capture at edge 0, first tick at edge 1. data_request pulses once per captured segment; abort wins over everything.
module multi_axis_step_generator #(
  parameter int NUM_AXES     = 3,
  parameter int COUNT_BITS   = 16,
  parameter int PERIOD_BITS  = 24,
  parameter int PULSE_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           data_available,
  output logic                           data_request,
  input  logic [NUM_AXES*COUNT_BITS-1:0] seg_steps,
  input  logic [NUM_AXES-1:0]            seg_dir,
  input  logic [PERIOD_BITS-1:0]         seg_period,
  input  logic                           abort,
  output logic [NUM_AXES-1:0]            step_out,
  output logic [NUM_AXES-1:0]            dir_out,
  output logic                           busy
);

  localparam int PW  = PERIOD_BITS + 1;
  localparam int CW  = COUNT_BITS + 1;
  localparam int PCW = $clog2(PULSE_CYCLES + 1);
  localparam logic [PW-1:0] MIN_P = PW'(2 * PULSE_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_nxt;
  logic [COUNT_BITS-1:0] m_q, ticks_left;
  logic [PW-1:0]         p_q, phase;
  logic [COUNT_BITS-1:0] steps_q [NUM_AXES];
  logic [CW-1:0]         acc_q   [NUM_AXES];
  logic [PCW-1:0]        pcnt_q  [NUM_AXES];

  logic                  tick, seg_end, capture;
  logic [COUNT_BITS-1:0] new_m;
  logic [PW-1:0]         new_p;
  logic [CW-1:0]         acc_sum [NUM_AXES];
  logic [NUM_AXES-1:0]   fire;

  assign busy = (state == RUN);

  // Ticks land where phase reads 1; the segment closes one cycle before the next would-be tick.
  always_comb begin
    tick      = (state == RUN) && (ticks_left != '0) && (phase == PW'(1));
    seg_end   = (state == RUN) && (ticks_left == '0) && (phase == PW'(2));
    capture   = data_available && !data_request && !abort && ((state == IDLE) || seg_end);
    state_nxt = state;
    if (abort)        state_nxt = IDLE;
    else if (capture) state_nxt = RUN;
    else if (seg_end) state_nxt = IDLE;
  end

  always_comb begin
    new_m = '0;
    for (int i = 0; i < NUM_AXES; i++)
      if (seg_steps[i*COUNT_BITS +: COUNT_BITS] > new_m)
        new_m = seg_steps[i*COUNT_BITS +: COUNT_BITS];
    new_p = (PW'(seg_period) > MIN_P) ? PW'(seg_period) : MIN_P;
  end

  always_comb begin
    fire = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      acc_sum[i] = acc_q[i] + CW'(steps_q[i]);
      fire[i]    = (acc_sum[i] >= CW'(m_q));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_request <= 1'b0;
      step_out     <= '0;
      dir_out      <= '0;
      m_q          <= '0;
      ticks_left   <= '0;
      p_q          <= '0;
      phase        <= '0;
      for (int i = 0; i < NUM_AXES; i++) begin
        steps_q[i] <= '0;
        acc_q[i]   <= '0;
        pcnt_q[i]  <= '0;
      end
    end else begin
      data_request <= capture;
      if (abort) begin
        step_out <= '0;
        for (int i = 0; i < NUM_AXES; i++) pcnt_q[i] <= '0;
      end else begin
        if (capture) begin
          dir_out    <= seg_dir;
          m_q        <= new_m;
          p_q        <= new_p;
          ticks_left <= new_m;
          // An empty segment skips straight to the end condition on the next edge.
          phase      <= (new_m == '0) ? PW'(2) : PW'(1);
          for (int i = 0; i < NUM_AXES; i++) begin
            steps_q[i] <= seg_steps[i*COUNT_BITS +: COUNT_BITS];
            acc_q[i]   <= CW'(new_m >> 1);
          end
        end else if (tick) begin
          ticks_left <= ticks_left - 1'b1;
          phase      <= p_q;
          for (int i = 0; i < NUM_AXES; i++)
            acc_q[i] <= fire[i] ? (acc_sum[i] - CW'(m_q)) : acc_sum[i];
        end else if (state == RUN) begin
          phase <= phase - 1'b1;
        end

        for (int i = 0; i < NUM_AXES; i++) begin
          if (tick && fire[i]) begin
            step_out[i] <= 1'b1;
            pcnt_q[i]   <= PCW'(PULSE_CYCLES - 1);
          end else if (pcnt_q[i] != '0) begin
            pcnt_q[i]   <= pcnt_q[i] - 1'b1;
          end else begin
            step_out[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_axis_step_generator.sv
// Directed bench for multi_axis_step_generator; drives and samples on the falling edge,
// so the value seen at the negedge after rising edge k is "cycle k".
module tb_multi_axis_step_generator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_available = 1'b0;
  logic        abort = 1'b0;
  logic [47:0] seg_steps = '0;
  logic [2:0]  seg_dir = '0;
  logic [23:0] seg_period = '0;
  logic        data_request;
  logic [2:0]  step_out;
  logic [2:0]  dir_out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int drc;
  logic e0, e1;

  always #5 clk = ~clk;

  multi_axis_step_generator #(
    .NUM_AXES(3), .COUNT_BITS(16), .PERIOD_BITS(24), .PULSE_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_available(data_available), .data_request(data_request),
    .seg_steps(seg_steps), .seg_dir(seg_dir), .seg_period(seg_period),
    .abort(abort), .step_out(step_out), .dir_out(dir_out), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2,
                         input logic [2:0] d, input logic [23:0] p);
    seg_steps      = {s2, s1, s0};
    seg_dir        = d;
    seg_period     = p;
    data_available = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst step", 32'(step_out), 0);
    chk("rst dir", 32'(dir_out), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst dreq", 32'(data_request), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle busy", 32'(busy), 0);

    // Basic segment {4,2,0}, period 10.
    present(16'd4, 16'd2, 16'd0, 3'b110, 24'd10);
    @(negedge clk);
    chk("t1 c0 dreq", 32'(data_request), 1);
    chk("t1 c0 busy", 32'(busy), 1);
    chk("t1 c0 dir", 32'(dir_out), 32'b110);
    chk("t1 c0 step", 32'(step_out), 0);
    data_available = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      e0 = (k >= 1) && (k <= 34) && (((k - 1) % 10) < 4);
      e1 = ((k >= 1) && (k <= 4)) || ((k >= 21) && (k <= 24));
      chk($sformatf("t1 step k=%0d", k), 32'(step_out), 32'({1'b0, e1, e0}));
      chk($sformatf("t1 busy k=%0d", k), 32'(busy), 32'(k < 40));
      chk($sformatf("t1 dreq k=%0d", k), 32'(data_request), 0);
    end

    // Back-to-back: A={1,1,1} P=10, B={2,0,1} P=8 queued behind it.
    present(16'd1, 16'd1, 16'd1, 3'b001, 24'd10);
    @(negedge clk);
    chk("t2 c0 dreq", 32'(data_request), 1);
    drc = 1;
    present(16'd2, 16'd0, 16'd1, 3'b100, 24'd8);
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      if (data_request) drc++;
      chk($sformatf("t2 busy k=%0d", k), 32'(busy), 32'(k < 26));
      if (k == 1)  chk("t2 step c1", 32'(step_out), 32'b111);
      if (k == 5)  chk("t2 step c5", 32'(step_out), 0);
      if (k == 9)  chk("t2 dir c9", 32'(dir_out), 32'b001);
      if (k == 10) begin
        chk("t2 dreq c10", 32'(data_request), 1);
        chk("t2 dir c10", 32'(dir_out), 32'b100);
        data_available = 1'b0;
      end
      if (k == 11) chk("t2 step c11", 32'(step_out), 32'b101);
      if (k == 19) chk("t2 step c19", 32'(step_out), 32'b001);
    end
    chk("t2 dreq pulses", 32'(drc), 2);

    // Short period stretched to 2*PULSE_CYCLES = 8.
    present(16'd3, 16'd0, 16'd0, 3'b000, 24'd3);
    @(negedge clk);
    data_available = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      e0 = (k <= 20) && (((k - 1) % 8) < 4);
      chk($sformatf("t3 step k=%0d", k), 32'(step_out), 32'({2'b00, e0}));
      chk($sformatf("t3 busy k=%0d", k), 32'(busy), 32'(k < 24));
    end

    // All-zero segment followed by a queued one.
    present(16'd0, 16'd0, 16'd0, 3'b011, 24'd5);
    @(negedge clk);
    chk("t4 c0 dreq", 32'(data_request), 1);
    chk("t4 c0 busy", 32'(busy), 1);
    chk("t4 c0 dir", 32'(dir_out), 32'b011);
    present(16'd1, 16'd0, 16'd0, 3'b010, 24'd8);
    @(negedge clk);
    chk("t4 c1 busy", 32'(busy), 0);
    chk("t4 c1 dreq", 32'(data_request), 0);
    chk("t4 c1 step", 32'(step_out), 0);
    @(negedge clk);
    chk("t4 c2 dreq", 32'(data_request), 1);
    chk("t4 c2 busy", 32'(busy), 1);
    chk("t4 c2 dir", 32'(dir_out), 32'b010);
    data_available = 1'b0;
    @(negedge clk);
    chk("t4 c3 step", 32'(step_out), 32'b001);
    repeat (9) @(negedge clk);
    chk("t4 c12 busy", 32'(busy), 0);

    // Abort at cycle 15 with another segment on offer.
    present(16'd4, 16'd2, 16'd0, 3'b101, 24'd10);
    @(negedge clk);
    data_available = 1'b0;
    repeat (14) @(negedge clk);
    chk("t5 c14 step", 32'(step_out), 32'b001);
    abort = 1'b1;
    present(16'd1, 16'd1, 16'd1, 3'b010, 24'd8);
    @(negedge clk);
    chk("t5 c15 step", 32'(step_out), 0);
    chk("t5 c15 busy", 32'(busy), 0);
    chk("t5 c15 dir", 32'(dir_out), 32'b101);
    chk("t5 c15 dreq", 32'(data_request), 0);
    abort = 1'b0;
    data_available = 1'b0;
    @(negedge clk);
    chk("t5 c16 busy", 32'(busy), 0);
    chk("t5 c16 dreq", 32'(data_request), 0);

    // Abort in the middle of a pulse.
    present(16'd4, 16'd2, 16'd0, 3'b101, 24'd10);
    @(negedge clk);
    data_available = 1'b0;
    @(negedge clk);
    chk("t5b c1 step", 32'(step_out), 32'b011);
    abort = 1'b1;
    @(negedge clk);
    chk("t5b c2 step", 32'(step_out), 0);
    chk("t5b c2 busy", 32'(busy), 0);
    abort = 1'b0;
    @(negedge clk);
    chk("t5b c3 step", 32'(step_out), 0);

    // Asynchronous reset mid-pulse, then a fresh segment.
    present(16'd4, 16'd2, 16'd0, 3'b111, 24'd10);
    @(negedge clk);
    data_available = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6 c2 step", 32'(step_out), 32'b011);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 arst step", 32'(step_out), 0);
    chk("t6 arst dir", 32'(dir_out), 0);
    chk("t6 arst busy", 32'(busy), 0);
    chk("t6 arst dreq", 32'(data_request), 0);
    @(negedge clk);
    rst_n = 1'b1;
    present(16'd2, 16'd0, 16'd0, 3'b001, 24'd8);
    @(negedge clk);
    chk("t6 c0 dreq", 32'(data_request), 1);
    chk("t6 c0 busy", 32'(busy), 1);
    chk("t6 c0 dir", 32'(dir_out), 32'b001);
    data_available = 1'b0;
    @(negedge clk);
    chk("t6 c1 step", 32'(step_out), 32'b001);
    repeat (18) @(negedge clk);
    chk("t6 end busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_axis_step_generator.md
MULTI_AXIS_STEP_GENERATOR -- requirements
Module: multi_axis_step_generator

Interface
REQ-001 SHALL have parameter NUM_AXES, default 3: number of coordinated step/dir channels.
REQ-002 SHALL have parameter COUNT_BITS, default 16: width of each per-axis step count.
REQ-003 SHALL have parameter PERIOD_BITS, default 24: width of the tick period in clk cycles.
REQ-004 SHALL have parameter PULSE_CYCLES, default 4: step pulse high time in clk cycles, minimum 1.
REQ-005 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port data_available  input  1  a segment is present on the seg_* inputs and may be captured now.
REQ-008 SHALL have port data_request  output  1  one-cycle pulse acknowledging capture; the producer pops its segment on it.
REQ-009 SHALL have port seg_steps  input  NUM_AXES*COUNT_BITS  per-axis unsigned step count; axis i in bits [i*COUNT_BITS +: COUNT_BITS].
REQ-010 SHALL have port seg_dir  input  NUM_AXES  per-axis direction.
REQ-011 SHALL have port seg_period  input  PERIOD_BITS  clk cycles per tick.
REQ-012 SHALL have port abort  input  1  synchronous stop request.
REQ-013 SHALL have port step_out  output  NUM_AXES  step pulses.
REQ-014 SHALL have port dir_out  output  NUM_AXES  registered direction.
REQ-015 SHALL have port busy  output  1  high while a segment executes.

Function
REQ-016 SHALL implement two states, IDLE and RUN; busy = (state == RUN).
REQ-017 SHALL capture a segment on an edge where data_available=1, data_request=0, abort=0, and state is IDLE or RUN at its final cycle (REQ-022); that edge is cycle 0.
REQ-018 SHALL drive data_request high for exactly the one cycle following each capture and never capture while data_request=1.
REQ-019 SHALL at capture register dir_out <= seg_dir, master count M = max over axes of seg_steps, effective period P = max(seg_period, 2*PULSE_CYCLES), per-axis accumulator <= M>>1 (COUNT_BITS+1 bits wide).
REQ-020 SHALL issue M ticks at cycles 1, 1+P, ..., 1+(M-1)*P; on each tick per axis: acc += steps[i]; if acc >= M then acc -= M and a step pulse is started on that axis.
REQ-021 SHALL hold step_out[i] high for exactly PULSE_CYCLES cycles from the tick cycle; each axis emits exactly seg_steps[i] pulses per segment, none after the segment ends.
REQ-022 SHALL end the segment at cycle M*P; with a capturable segment then present the next one loads on that edge with no idle cycle, otherwise state -> IDLE.
REQ-023 SHALL treat M=0 (all axes zero) as consumed: data_request pulses, no steps, dir_out still updated, state -> IDLE at cycle 1.
REQ-024 SHALL on abort=1 at any edge go to IDLE, drop step_out to 0 on that edge, not capture, and keep dir_out.
REQ-025 SHALL use unsigned arithmetic with no overflow at M = 2^COUNT_BITS-1, P = 2^PERIOD_BITS-1.
REQ-026 SHALL keep the segment duration independent of data_available once RUN is entered.

Reset
REQ-027 SHALL on rst_n=0, asynchronously and immediately, force state IDLE, step_out=0, dir_out=0, data_request=0, busy=0, and clear all counters and accumulators, including mid-segment.
REQ-028 SHALL first capture on the first rising edge at which rst_n=1 and REQ-017 holds.

Verification
REQ-029 SHALL verify: seg_steps={4,2,0}, P=10, PULSE_CYCLES=4 -> axis0 rises at cycles 1,11,21,31; axis1 at 1,21; axis2 silent; each pulse 4 cycles wide; busy falls at cycle 40.
REQ-030 SHALL verify: two segments queued back-to-back -> second captured at cycle M*P of the first, data_request pulses twice, no busy gap.
REQ-031 SHALL verify: seg_period=3, PULSE_CYCLES=4 -> effective P=8, ticks at cycles 1,9,17,...
REQ-032 SHALL verify: all-zero segment -> one data_request pulse, no step pulses, busy high for cycle 0 to 1 only, next segment captured no earlier than cycle 2.
REQ-033 SHALL verify: abort at cycle 15 of the REQ-029 segment -> step_out=0 from cycle 15, IDLE, dir_out unchanged, no data_request.
REQ-034 SHALL verify: rst_n low mid-pulse -> all outputs 0 without a clock edge; after release a new segment runs from cycle 0.
